// File: rtl/artyz7_led_driver.sv
// Arty Z7 LED driver: per-LED off/on/blink/pulse modes with PWM brightness,
// configured through a valid/ready command port, with registered LED outputs.
module artyz7_led_driver #(
  parameter int num_leds          = 4,
  parameter int pwm_bits          = 8,
  parameter int blink_half_period = 62500000,
  parameter int pulse_cycles      = 12500000
) (
  input  logic                clk_ext,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_index,
  input  logic [1:0]          cmd_mode,
  input  logic [pwm_bits-1:0] cmd_brightness,
  output logic                cmd_error,
  output logic [0:num_leds-1] led
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PULSE = 2'b11
  } mode_t;

  typedef enum logic {
    PULSE_IDLE   = 1'b0,
    PULSE_ACTIVE = 1'b1
  } pulse_t;

  localparam int bw = (blink_half_period > 2) ? $clog2(blink_half_period) : 1;
  localparam int pw = (pulse_cycles > 1) ? $clog2(pulse_cycles) : 1;

  // PWM counter tops out one below all-ones so full brightness never drops out.
  localparam logic [pwm_bits-1:0] pwm_last   = {{(pwm_bits-1){1'b1}}, 1'b0};
  localparam logic [bw-1:0]       blink_last = bw'(blink_half_period - 1);
  localparam logic [pw-1:0]       pulse_load = pw'(pulse_cycles - 1);
  localparam logic [2:0]          led_count  = 3'(num_leds);

  logic [pwm_bits-1:0] pwm_cnt_r;
  logic [bw-1:0]       blink_cnt_r;
  logic                blink_phase_r;
  mode_t               mode_r   [num_leds];
  logic [pwm_bits-1:0] bright_r [num_leds];
  pulse_t              pstate_r [num_leds];
  logic [pw-1:0]       pcnt_r   [num_leds];

  logic                accept_s;
  logic                bad_index_s;
  logic                hit_s      [num_leds];
  logic [0:num_leds-1] led_next_s;

  // Command decode and per-LED output function from the registered state.
  always_comb begin
    accept_s    = cmd_valid & cmd_ready;
    bad_index_s = ({1'b0, cmd_index} >= led_count);
    led_next_s  = '0;
    for (int i = 0; i < num_leds; i++) begin
      hit_s[i] = accept_s && !bad_index_s && (cmd_index == 2'(i));
      case (mode_r[i])
        MODE_OFF:   led_next_s[i] = 1'b0;
        MODE_ON:    led_next_s[i] = (pwm_cnt_r < bright_r[i]);
        MODE_BLINK: led_next_s[i] = (pwm_cnt_r < bright_r[i]) & blink_phase_r;
        MODE_PULSE: led_next_s[i] = (pwm_cnt_r < bright_r[i]) & (pstate_r[i] == PULSE_ACTIVE);
        default:    led_next_s[i] = 1'b0;
      endcase
    end
  end

  // Shared counters, handshake, per-LED configuration and pulse state machines.
  always_ff @(posedge clk_ext) begin
    if (!reset_n) begin
      cmd_ready     <= 1'b0;
      cmd_error     <= 1'b0;
      led           <= '0;
      pwm_cnt_r     <= '0;
      blink_cnt_r   <= '0;
      blink_phase_r <= 1'b0;
      for (int i = 0; i < num_leds; i++) begin
        mode_r[i]   <= MODE_OFF;
        bright_r[i] <= '0;
        pstate_r[i] <= PULSE_IDLE;
        pcnt_r[i]   <= '0;
      end
    end else begin
      // Ready drops for exactly one cycle after each transfer.
      cmd_ready <= !accept_s;
      if (accept_s && bad_index_s) begin
        cmd_error <= 1'b1;
      end
      led <= led_next_s;

      if (pwm_cnt_r == pwm_last) begin
        pwm_cnt_r <= '0;
      end else begin
        pwm_cnt_r <= pwm_cnt_r + pwm_bits'(1);
      end

      if (blink_cnt_r == blink_last) begin
        blink_cnt_r   <= '0;
        blink_phase_r <= !blink_phase_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + bw'(1);
      end

      for (int i = 0; i < num_leds; i++) begin
        if (hit_s[i]) begin
          mode_r[i]   <= mode_t'(cmd_mode);
          bright_r[i] <= cmd_brightness;
          if (mode_t'(cmd_mode) == MODE_PULSE) begin
            pstate_r[i] <= PULSE_ACTIVE;
            pcnt_r[i]   <= pulse_load;
          end else begin
            pstate_r[i] <= PULSE_IDLE;
            pcnt_r[i]   <= '0;
          end
        end else begin
          case (pstate_r[i])
            PULSE_ACTIVE: begin
              if (pcnt_r[i] == '0) begin
                pstate_r[i] <= PULSE_IDLE;
                mode_r[i]   <= MODE_OFF;
              end else begin
                pcnt_r[i] <= pcnt_r[i] - pw'(1);
              end
            end
            PULSE_IDLE: pcnt_r[i] <= '0;
            default: begin
              pstate_r[i] <= PULSE_IDLE;
              pcnt_r[i]   <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_artyz7_led_driver.sv
// Directed self-checking bench for artyz7_led_driver: a 4-LED instance with
// short blink/pulse timing plus a 2-LED instance for out-of-range indices.
module tb_artyz7_led_driver;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       v1 = 1'b0;
  logic       v2 = 1'b0;
  logic [1:0] cmd_index = 2'd0;
  logic [1:0] cmd_mode = 2'd0;
  logic [7:0] cmd_brightness = 8'd0;
  logic       rdy1, err1, rdy2, err2;
  logic [0:3] led1;
  logic [0:1] led2;

  int compared = 0;
  int mismatched = 0;
  int hi_cnt = 0;
  bit cnt_en = 1'b0;

  always #5 clk = ~clk;

  artyz7_led_driver #(.num_leds(4), .pwm_bits(8), .blink_half_period(4), .pulse_cycles(6)) dut (
    .clk_ext(clk), .reset_n(reset_n), .cmd_valid(v1), .cmd_ready(rdy1),
    .cmd_index(cmd_index), .cmd_mode(cmd_mode), .cmd_brightness(cmd_brightness),
    .cmd_error(err1), .led(led1)
  );

  artyz7_led_driver #(.num_leds(2), .pwm_bits(8), .blink_half_period(4), .pulse_cycles(6)) dut2 (
    .clk_ext(clk), .reset_n(reset_n), .cmd_valid(v2), .cmd_ready(rdy2),
    .cmd_index(cmd_index), .cmd_mode(cmd_mode), .cmd_brightness(cmd_brightness),
    .cmd_error(err2), .led(led2)
  );

  // High-cycle counter for led[3] of the 4-LED instance.
  always @(negedge clk) begin
    if (cnt_en) hi_cnt = hi_cnt + int'(led1[3]);
  end

  // Called at a negedge; returns at the negedge of cycle N+1 after the transfer.
  task automatic send(input bit which, input logic [1:0] idx, input logic [1:0] md,
                      input logic [7:0] br);
    int  waited;
    bit  ok;
    cmd_index = idx;
    cmd_mode = md;
    cmd_brightness = br;
    if (which) v2 = 1'b1; else v1 = 1'b1;
    waited = 0;
    ok = 1'b0;
    while (!ok && waited < 10) begin
      ok = which ? rdy2 : rdy1;
      @(negedge clk);
      waited++;
    end
    v1 = 1'b0;
    v2 = 1'b0;
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: ready never seen, got 0 required 1");
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    compared++;
    if (led1 !== 4'b0000 || rdy1 !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_hold: led=%b ready=%b required led=0000 ready=0", led1, rdy1);
    end
    reset_n = 1'b1;
    @(negedge clk);
    compared++;
    if (rdy1 !== 1'b1 || err1 !== 1'b0 || rdy2 !== 1'b1 || err2 !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_release: ready=%b err=%b ready2=%b err2=%b required 1 0 1 0",
               rdy1, err1, rdy2, err2);
    end
  endtask

  task automatic test_on_full();
    int bad;
    send(1'b0, 2'd1, 2'b01, 8'd255);
    compared++;
    if (rdy1 !== 1'b0 || led1 !== 4'b0000) begin
      mismatched++;
      $display("FAIL on_full_n1: ready=%b led=%b required ready=0 led=0000", rdy1, led1);
    end
    @(negedge clk);
    compared++;
    if (rdy1 !== 1'b1 || led1 !== 4'b0100) begin
      mismatched++;
      $display("FAIL on_full_n2: ready=%b led=%b required ready=1 led=0100", rdy1, led1);
    end
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (led1 !== 4'b0100) bad++;
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("FAIL on_full_steady: %0d cycles off pattern, required 0", bad);
    end
  endtask

  task automatic test_pwm();
    int on0, on1;
    send(1'b0, 2'd0, 2'b01, 8'd64);
    repeat (2) @(negedge clk);
    on0 = 0;
    on1 = 0;
    for (int i = 0; i < 2550; i++) begin
      on0 += int'(led1[0]);
      on1 += int'(led1[1]);
      @(negedge clk);
    end
    compared++;
    if (on0 != 640) begin
      mismatched++;
      $display("FAIL pwm_duty64: high %0d of 2550 cycles, required 640", on0);
    end
    compared++;
    if (on1 != 2550) begin
      mismatched++;
      $display("FAIL pwm_neighbour: led1 high %0d of 2550, required 2550", on1);
    end
    send(1'b0, 2'd0, 2'b01, 8'd0);
    repeat (2) @(negedge clk);
    on0 = 0;
    for (int i = 0; i < 255; i++) begin
      on0 += int'(led1[0]);
      @(negedge clk);
    end
    compared++;
    if (on0 != 0) begin
      mismatched++;
      $display("FAIL pwm_duty0: high %0d of 255 cycles, required 0", on0);
    end
    send(1'b0, 2'd1, 2'b00, 8'd0);
  endtask

  task automatic test_blink();
    bit s2 [24];
    bit s3 [24];
    int other, skew, inv, highs;
    send(1'b0, 2'd2, 2'b10, 8'd255);
    send(1'b0, 2'd3, 2'b10, 8'd255);
    repeat (2) @(negedge clk);
    other = 0;
    for (int i = 0; i < 24; i++) begin
      s2[i] = led1[2];
      s3[i] = led1[3];
      if (led1[0] !== 1'b0 || led1[1] !== 1'b0) other++;
      @(negedge clk);
    end
    skew = 0;
    inv = 0;
    highs = 0;
    for (int i = 0; i < 24; i++) begin
      if (s2[i] != s3[i]) skew++;
      if (i < 16) highs += int'(s2[i]);
      if (i < 20 && s2[i + 4] == s2[i]) inv++;
    end
    compared++;
    if (skew != 0) begin
      mismatched++;
      $display("FAIL blink_phase: %0d cycles led2!=led3, required 0", skew);
    end
    compared++;
    if (inv != 0 || highs != 8) begin
      mismatched++;
      $display("FAIL blink_period: non-4/4 points=%0d highs=%0d, required 0 and 8", inv, highs);
    end
    compared++;
    if (other != 0) begin
      mismatched++;
      $display("FAIL blink_others: %0d cycles led0/led1 lit, required 0", other);
    end
    send(1'b0, 2'd2, 2'b00, 8'd0);
    send(1'b0, 2'd3, 2'b00, 8'd0);
    @(negedge clk);
    compared++;
    if (led1 !== 4'b0000) begin
      mismatched++;
      $display("FAIL blink_off: led=%b required 0000", led1);
    end
  endtask

  task automatic test_pulse();
    hi_cnt = 0;
    cnt_en = 1'b1;
    send(1'b0, 2'd3, 2'b11, 8'd255);
    repeat (30) @(negedge clk);
    cnt_en = 1'b0;
    compared++;
    if (hi_cnt != 6) begin
      mismatched++;
      $display("FAIL pulse_single: high %0d cycles, required 6", hi_cnt);
    end
    compared++;
    if (led1 !== 4'b0000) begin
      mismatched++;
      $display("FAIL pulse_done: led=%b required 0000", led1);
    end
    hi_cnt = 0;
    cnt_en = 1'b1;
    send(1'b0, 2'd3, 2'b11, 8'd255);
    repeat (2) @(negedge clk);
    send(1'b0, 2'd3, 2'b11, 8'd255);
    repeat (30) @(negedge clk);
    cnt_en = 1'b0;
    compared++;
    if (hi_cnt != 9) begin
      mismatched++;
      $display("FAIL pulse_retrigger: high %0d cycles, required 9", hi_cnt);
    end
  endtask

  task automatic test_bad_index();
    compared++;
    if (err2 !== 1'b0) begin
      mismatched++;
      $display("FAIL bad_idx_pre: err=%b required 0", err2);
    end
    send(1'b1, 2'd3, 2'b01, 8'd255);
    compared++;
    if (err2 !== 1'b1 || rdy2 !== 1'b0 || led2 !== 2'b00) begin
      mismatched++;
      $display("FAIL bad_idx_n1: err=%b ready=%b led=%b required 1 0 00", err2, rdy2, led2);
    end
    send(1'b1, 2'd1, 2'b01, 8'd255);
    @(negedge clk);
    compared++;
    if (err2 !== 1'b1 || led2 !== 2'b01) begin
      mismatched++;
      $display("FAIL bad_idx_sticky: err=%b led=%b required 1 01", err2, led2);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int lit;
    send(1'b0, 2'd3, 2'b11, 8'd255);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    compared++;
    if (err2 !== 1'b0 || led2 !== 2'b00 || led1 !== 4'b0000 || rdy1 !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_pulse: err2=%b led2=%b led=%b ready=%b required 0 00 0000 0",
               err2, led2, led1, rdy1);
    end
    lit = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (led1 !== 4'b0000) lit++;
    end
    compared++;
    if (lit != 0) begin
      mismatched++;
      $display("FAIL reset_discard: %0d cycles lit after reset, required 0", lit);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_on_full();
    test_pwm();
    test_blink();
    test_pulse();
    test_bad_index();
    test_reset_mid_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
